// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Operand-fetch stage feeding the systolic array's top and left input buffers.
// On a start command it reads MATRIX_SIZE consecutive DPRAM bytes, beginning at
// base_addr, and writes them to buffer addresses 0..MATRIX_SIZE-1 of the
// selected buffer. It can optionally end with a one-cycle swap pulse to that
// buffer. Sequence: IDLE -> READ -> DRAIN -> (SWAP) -> DONE -> IDLE.
//
// Optional feature: define OPERAND_LOADER_STRIDE_EN to add a 'stride' input.
// The stride is latched at start, and the read address becomes
// base + rd_idx*stride, wrapping modulo 2^DP_ADDR_WIDTH. Without the macro the
// stride is fixed at 1.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               command strobe (sampled only in IDLE)
//   sel_top             1 = top buffer, 0 = left buffer (latched at start)
//   swap_req            pulse the selected swap_buffers after loading (latched)
//   base_addr           first DPRAM address (latched at start)
//   stride              address step (only with OPERAND_LOADER_STRIDE_EN)
//   busy                high from the cycle after accept through DONE
//   done                one-cycle completion pulse
//   ram_addr, ram_dout  DPRAM read port (synchronous read, 1-cycle latency)
//   load_en_*, addr_*, data_in_*, swap_buffers_*   top / left buffer ports
// -----------------------------------------------------------------------------
module operand_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 8,  // must be >= 2
  parameter int ADDR_WIDTH    = $clog2(MATRIX_SIZE),
  parameter int DP_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sel_top,
  input  logic                     swap_req,
  input  logic [DP_ADDR_WIDTH-1:0] base_addr,
`ifdef OPERAND_LOADER_STRIDE_EN
  input  logic [DP_ADDR_WIDTH-1:0] stride,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [DP_ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     load_en_top,
  output logic [ADDR_WIDTH-1:0]    addr_top,
  output logic [DATA_WIDTH-1:0]    data_in_top,
  output logic                     swap_buffers_top,
  output logic                     load_en_left,
  output logic [ADDR_WIDTH-1:0]    addr_left,
  output logic [DATA_WIDTH-1:0]    data_in_left,
  output logic                     swap_buffers_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SWAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MATRIX_SIZE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    sel_top_q;
  logic                    swap_q;
  logic [DP_ADDR_WIDTH-1:0] stride_q;

  // One-deep load pipeline: the read issued in a READ cycle returns data in
  // the next cycle, so this tags that cycle with the buffer index.
  logic                    ld_valid;
  logic [ADDR_WIDTH-1:0]   ld_idx;

`ifndef OPERAND_LOADER_STRIDE_EN
  assign stride_q = DP_ADDR_WIDTH'(1);
`endif

  // NOTE: state registers use non-blocking (<=) assignments so that every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      rd_idx            <= '0;
      sel_top_q         <= 1'b0;
      swap_q            <= 1'b0;
      ram_addr          <= '0;
      ld_valid          <= 1'b0;
      ld_idx            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      swap_buffers_top  <= 1'b0;
      swap_buffers_left <= 1'b0;
`ifdef OPERAND_LOADER_STRIDE_EN
      stride_q          <= '0;
`endif
    end else begin
      // Single-cycle pulses default low; only the states below raise them.
      ld_valid          <= 1'b0;
      ld_idx            <= '0;
      done              <= 1'b0;
      swap_buffers_top  <= 1'b0;
      swap_buffers_left <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_READ;
            busy      <= 1'b1;
            sel_top_q <= sel_top;
            swap_q    <= swap_req;
            rd_idx    <= '0;
            // Address for rd_idx = 0 is the base itself.
            ram_addr  <= base_addr;
`ifdef OPERAND_LOADER_STRIDE_EN
            stride_q  <= stride;
`endif
          end
        end

        S_READ: begin
          ld_valid <= 1'b1;
          ld_idx   <= rd_idx;
          if (rd_idx == LAST_IDX) begin
            // ram_addr holds its final value through DRAIN.
            state <= S_DRAIN;
          end else begin
            rd_idx   <= rd_idx + ADDR_WIDTH'(1);
            // Running sum equals base + rd_idx*stride, wrapping naturally.
            ram_addr <= ram_addr + stride_q;
          end
        end

        S_DRAIN: begin
          if (swap_q) begin
            state             <= S_SWAP;
            swap_buffers_top  <= sel_top_q;
            swap_buffers_left <= ~sel_top_q;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_SWAP: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer write ports. Read data is only valid in the cycle after its
  // address, so data_in passes ram_dout straight through while the pipeline
  // register is valid. Idle ports drive zeros.
  assign load_en_top  = ld_valid & sel_top_q;
  assign load_en_left = ld_valid & ~sel_top_q;

  assign addr_top     = load_en_top  ? ld_idx   : '0;
  assign data_in_top  = load_en_top  ? ram_dout : '0;
  assign addr_left    = load_en_left ? ld_idx   : '0;
  assign data_in_left = load_en_left ? ram_dout : '0;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Operand-fetch stage directly upstream of the systolic array's top and left input buffers.
- On a start command from the control FSM, it reads MATRIX_SIZE consecutive bytes from one DPRAM port and writes them into the selected buffer (top or left) at buffer addresses 0..MATRIX_SIZE-1.
- It can optionally finish with a buffer-swap pulse.
- It implements the FSM's LOAD_LEFT / LOAD_TOP (+SWAP) opcodes, so the FSM only issues a command and waits for done.

Parameters:
- DATA_WIDTH, 8, operand byte width (matches DPRAM and systolic data width).
- MATRIX_SIZE, 8, entries per buffer load.
- ADDR_WIDTH, $clog2(MATRIX_SIZE), buffer index width.
- DP_ADDR_WIDTH, 10, DPRAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- sel_top  in  1  1 = load top buffer, 0 = load left buffer; latched at start.
- swap_req  in  1  1 = pulse the selected swap_buffers after the last load; latched at start.
- base_addr  in  DP_ADDR_WIDTH  first DPRAM address; latched at start.
- busy  out  1  high from the cycle after start is accepted through the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- ram_addr  out  DP_ADDR_WIDTH  DPRAM read address.
- ram_dout  in  DATA_WIDTH  DPRAM read data; synchronous read, valid 1 cycle after ram_addr.
- load_en_top / addr_top / data_in_top  out  1 / ADDR_WIDTH / DATA_WIDTH  top buffer write port.
- swap_buffers_top  out  1  top buffer swap pulse.
- load_en_left / addr_left / data_in_left  out  1 / ADDR_WIDTH / DATA_WIDTH  left buffer write port.
- swap_buffers_left  out  1  left buffer swap pulse.

Behaviour:
- One clock domain; reset is asynchronous, active-high, on port rst.
- Reset values:
  - State = IDLE; all counters and latches = 0.
  - busy, done, all load_en_* and swap_buffers_* = 0.
  - ram_addr, addr_*, data_in_* = 0.
- State machine: IDLE -> READ -> DRAIN -> (SWAP) -> DONE -> IDLE.
- IDLE:
  - start=1 latches base_addr, sel_top and swap_req, clears rd_idx, and goes to READ.
  - start=0: remain in IDLE.
- READ (exactly MATRIX_SIZE cycles):
  - ram_addr = base + rd_idx, truncated to DP_ADDR_WIDTH, so addresses wrap modulo 2^DP_ADDR_WIDTH.
  - rd_idx increments each cycle; when rd_idx = MATRIX_SIZE-1, go to DRAIN.
- Load pipeline:
  - A 1-deep valid/index register tracks each issued read.
  - The cycle after address k is issued, the selected side drives load_en=1, addr=k, data_in=ram_dout.
  - The unselected side's load_en stays 0.
  - This produces MATRIX_SIZE consecutive load_en cycles, starting 1 cycle after the first READ cycle.
- DRAIN (1 cycle): carries the final load (index MATRIX_SIZE-1). ram_addr holds its last value.
- SWAP (1 cycle, only if swap_req latched): swap_buffers_<selected>=1; no load_en.
- DONE (1 cycle): done=1, then return to IDLE.
- Total latency from the start-sampling edge to the done cycle: MATRIX_SIZE+2 cycles, or MATRIX_SIZE+3 with swap.
- busy is high in READ, DRAIN, SWAP and DONE.
- When load_en_* is low, addr_* and data_in_* are driven 0.
- start while busy is ignored; no queuing.
- start in the DONE cycle is ignored.
- start in the first IDLE cycle after DONE is accepted.
- rst asserted mid-operation aborts immediately:
  - No further load_en, swap or done.
  - Partially loaded buffer contents are the consumer's responsibility.

Optional Feature:
- Macro: OPERAND_LOADER_STRIDE_EN.
- When defined:
  - Adds input stride [DP_ADDR_WIDTH], latched at start.
  - ram_addr = base + rd_idx*stride, truncated (wrap).
  - Stride 0 reads base repeatedly.
  - Used for column-major operand fetch.
- When undefined:
  - Port absent; stride is fixed at 1.
  - Behaviour is identical to the stride=1 case.

Test Plan:
- Left load: start, sel_top=0, swap_req=0, base=0x010, RAM[0x010..0x017]=0x01..0x08 -> load_en_left for 8 consecutive cycles with (addr,data)=(0,0x01)..(7,0x08); load_en_top never high; done exactly 10 cycles after the start edge; busy high 10 cycles.
- Top load with swap: sel_top=1, swap_req=1, base=0x100 -> 8 top loads, then a 1-cycle swap_buffers_top pulse, then done on the next cycle; swap_buffers_left stays 0.
- Wrap: base=0x3FC, DP_ADDR_WIDTH=10 -> ram_addr sequence 0x3FC,0x3FD,0x3FE,0x3FF,0x000,0x001,0x002,0x003.
- Busy collision: second start (sel_top=1) pulsed mid-READ of a left load -> ignored; no top loads; single done; a start in the IDLE cycle after done is accepted.
- Reset mid-op: rst pulsed after 3 load_en cycles -> all outputs 0 asynchronously; no done; a fresh start afterwards performs a full 8-entry load.
- Stride (OPERAND_LOADER_STRIDE_EN defined): base=0x000, stride=8 -> ram_addr 0x000,0x008,...,0x038; loads addr 0..7 in order.
